// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the four-source UART transmit arbiter.
package uart_tx_arbiter_pkg;

  localparam int NREQ = 4;
  localparam logic [6:0] EOL_DEFAULT = 7'h0A;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_GUARD = 2'd2,
    ST_WAIT  = 2'd3
  } state_t;

  function automatic logic [6:0] char_of(input logic [7*NREQ-1:0] data, input logic [1:0] idx);
    logic [6:0] c;
    c = data[6:0];
    case (idx)
      2'd0: c = data[6:0];
      2'd1: c = data[13:7];
      2'd2: c = data[20:14];
      2'd3: c = data[27:21];
    endcase
    return c;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter signals of the arbiter; master is the arbiter side.
interface uart_tx_arbiter_if;
  import uart_tx_arbiter_pkg::*;

  logic [NREQ-1:0]   req_valid;
  logic [7*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ack;
  logic              tx_load;
  logic [6:0]        tx_char;
  logic              tx_ready;
  logic [1:0]        grant;
  logic              locked;
  logic              busy;

  modport master (
    input  req_valid, req_data, tx_ready,
    output req_ack, tx_load, tx_char, grant, locked, busy
  );

  modport slave (
    output req_valid, req_data, tx_ready,
    input  req_ack, tx_load, tx_char, grant, locked, busy
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Rotate-priority encoder: first valid requester searching from rr_ptr+1 mod 4.
module uart_rr_pick
  import uart_tx_arbiter_pkg::*;
(
  input  logic [NREQ-1:0] req_valid,
  input  logic [1:0]      rr_ptr,
  output logic            any,
  output logic [1:0]      idx
);

  // Walk from farthest to nearest so the nearest valid requester wins.
  always_comb begin
    any = |req_valid;
    idx = rr_ptr;
    for (int k = NREQ; k >= 1; k--) begin
      if (req_valid[rr_ptr + 2'(k)]) idx = rr_ptr + 2'(k);
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter with line locking in front of a single 7-bit UART transmitter.
//   state | meaning
//   IDLE  | waiting for tx_ready and a request; runs the owner idle timeout
//   SEND  | tx_load / req_ack pulse, burst and EOL unlock check
//   GUARD | skip the transmitter's one-cycle ready drop
//   WAIT  | frame in flight, wait for tx_ready
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter logic [6:0]  EOL          = EOL_DEFAULT,
  parameter int unsigned MAX_BURST    = 80,
  parameter int unsigned IDLE_TIMEOUT = 65535
) (
  input  logic            clk,
  input  logic            reset,
  uart_tx_arbiter_if.master bus
);

  localparam logic [7:0]  BURST_LIM    = 8'(MAX_BURST);
  localparam logic [15:0] TIMEOUT_MAX  = 16'(IDLE_TIMEOUT);
  localparam logic [15:0] TIMEOUT_LAST = 16'(IDLE_TIMEOUT - 1);

  state_t      state;
  logic [1:0]  rr_ptr;
  logic [7:0]  burst_cnt;
  logic [7:0]  burst_next;
  logic [15:0] idle_cnt;
  logic        pick_any;
  logic [1:0]  pick_idx;

  uart_rr_pick u_pick (
    .req_valid (bus.req_valid),
    .rr_ptr    (rr_ptr),
    .any       (pick_any),
    .idx       (pick_idx)
  );

  assign burst_next  = burst_cnt + 8'd1;
  assign bus.tx_load = (state == ST_SEND);
  assign bus.req_ack = (state == ST_SEND) ? (4'b0001 << bus.grant) : '0;
  assign bus.busy    = (state != ST_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      rr_ptr      <= 2'd3;
      burst_cnt   <= '0;
      idle_cnt    <= '0;
      bus.locked  <= 1'b0;
      bus.grant   <= '0;
      bus.tx_char <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.locked) begin
            if (bus.req_valid[bus.grant]) begin
              if (bus.tx_ready) begin
                bus.tx_char <= char_of(bus.req_data, bus.grant);
                state       <= ST_SEND;
              end
            // The timeout only advances while the owner is silent, so a
            // request arriving on the expiry cycle keeps the lock.
            end else if (idle_cnt >= TIMEOUT_LAST) begin
              idle_cnt   <= TIMEOUT_MAX;
              bus.locked <= 1'b0;
              rr_ptr     <= bus.grant;
            end else begin
              idle_cnt <= idle_cnt + 16'd1;
            end
          end else if (bus.tx_ready && pick_any) begin
            bus.grant   <= pick_idx;
            bus.locked  <= 1'b1;
            burst_cnt   <= '0;
            idle_cnt    <= '0;
            bus.tx_char <= char_of(bus.req_data, pick_idx);
            state       <= ST_SEND;
          end
        end
        ST_SEND: begin
          burst_cnt <= burst_next;
          idle_cnt  <= '0;
          if (bus.tx_char == EOL || burst_next == BURST_LIM) begin
            bus.locked <= 1'b0;
            rr_ptr     <= bus.grant;
          end
          state <= ST_GUARD;
        end
        ST_GUARD: state <= ST_WAIT;
        ST_WAIT:  if (bus.tx_ready) state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench: stimulus queues expected (requester, char) loads; a monitor checks each tx_load.
module tb_uart_tx_arbiter;

  localparam int FRAME = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;

  uart_tx_arbiter_if bus();

  uart_tx_arbiter #(.EOL(7'h0A), .MAX_BURST(3), .IDLE_TIMEOUT(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] idx;
    logic [6:0] ch;
  } exp_t;

  int   tests = 0;
  int   fails = 0;
  exp_t exp_q[$];
  exp_t e;
  logic [6:0] q0[$], q1[$], q2[$], q3[$];
  int   frame_left = 0;
  bit   tx_hold = 1'b0;
  logic [3:0] acks;
  logic ld;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic expect_seq(input logic [1:0] idx, input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back({idx, 7'(s[i])});
  endtask

  task automatic push_req(input int r, input string s);
    for (int i = 0; i < s.len(); i++) begin
      case (r)
        0: q0.push_back(7'(s[i]));
        1: q1.push_back(7'(s[i]));
        2: q2.push_back(7'(s[i]));
        default: q3.push_back(7'(s[i]));
      endcase
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_load(input string name, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.tx_load && n < budget);
    if (!bus.tx_load) chk(name, bus.tx_load, 1);
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  // Transmitter model: ready drops after a load for FRAME cycles; not reset.
  initial begin
    bus.tx_ready = 1'b1;
    forever begin
      @(negedge clk);
      ld = bus.tx_load;
      @(posedge clk);
      #1;
      if (ld) frame_left = FRAME;
      else if (frame_left > 0) frame_left--;
      bus.tx_ready = (frame_left == 0) && !tx_hold;
    end
  end

  // Requesters: hold each character until its ack, then present the next.
  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    forever begin
      @(negedge clk);
      acks = bus.req_ack;
      @(posedge clk);
      #1;
      if (acks[0] && q0.size() > 0) void'(q0.pop_front());
      if (acks[1] && q1.size() > 0) void'(q1.pop_front());
      if (acks[2] && q2.size() > 0) void'(q2.pop_front());
      if (acks[3] && q3.size() > 0) void'(q3.pop_front());
      bus.req_valid = {q3.size() > 0, q2.size() > 0, q1.size() > 0, q0.size() > 0};
      bus.req_data  = {(q3.size() > 0) ? q3[0] : 7'h0, (q2.size() > 0) ? q2[0] : 7'h0,
                       (q1.size() > 0) ? q1[0] : 7'h0, (q0.size() > 0) ? q0[0] : 7'h0};
    end
  end

  // Monitor / scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.tx_load) begin
        chk("load_with_ready", bus.tx_ready, 1);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_load: got char %0h, expected no load", bus.tx_char);
        end else begin
          e = exp_q.pop_front();
          chk("tx_char", bus.tx_char, e.ch);
          chk("req_ack", bus.req_ack, 4'b0001 << e.idx);
          chk("grant", bus.grant, e.idx);
        end
      end else if (bus.req_ack != 4'b0000) begin
        chk("ack_without_load", bus.req_ack, 0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_tx_load", bus.tx_load, 0);
    chk("rst_req_ack", bus.req_ack, 0);
    chk("rst_locked", bus.locked, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_tx_char", bus.tx_char, 0);
    chk("rst_grant", bus.grant, 0);
    reset = 1'b0;

    // Single source, then rr_ptr=0 lets requester 1 go ahead of 0.
    expect_seq(0, "AB\n");
    push_req(0, "AB\n");
    wait_done("single_done", 300);
    chk("single_unlock", bus.locked, 0);
    chk("single_grant", bus.grant, 0);
    expect_seq(1, "D\n");
    expect_seq(0, "C\n");
    expect_seq(1, "E\n");
    push_req(0, "C\n");
    push_req(1, "D\nE\n");
    wait_done("eol_release_done", 400);

    // Line lock: requester 1's whole line before requester 2.
    do_reset();
    expect_seq(1, "XY\n");
    expect_seq(2, "MN\n");
    expect_seq(1, "Q\n");
    push_req(1, "XY\nQ\n");
    push_req(2, "MN\n");
    wait_done("line_lock_done", 600);

    // Burst limit of 3 with requester 0 arriving after the first Z.
    do_reset();
    expect_seq(3, "ZZZ");
    expect_seq(0, "a\n");
    expect_seq(3, "ZZZ");
    push_req(3, "ZZZZZZ");
    wait_load("burst_first", 50);
    push_req(0, "a\n");
    wait_load("burst_second", 50);
    @(negedge clk);
    chk("burst_still_locked", bus.locked, 1);
    wait_load("burst_third", 50);
    @(negedge clk);
    chk("burst_unlock", bus.locked, 0);
    wait_done("burst_done", 600);

    // Idle timeout: 10 locked idle cycles, then an arbitration cycle.
    do_reset();
    expect_seq(0, "A");
    expect_seq(1, "B\n");
    push_req(0, "A");
    push_req(1, "B\n");
    wait_load("timeout_first", 50);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.busy && n < 50);
    n = 0;
    while (!bus.tx_load && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("timeout_idle_cycles", n, 11);
    chk("timeout_grant", bus.grant, 1);
    wait_done("timeout_done", 300);

    // Reset during WAIT with the transmitter still busy.
    do_reset();
    expect_seq(1, "K");
    push_req(1, "K\n");
    wait_load("mid_first", 50);
    repeat (3) @(negedge clk);
    chk("mid_pre_locked", bus.locked, 1);
    tx_hold = 1'b1;
    expect_seq(0, "R\n");
    expect_seq(1, "\n");
    push_req(0, "R\n");
    #1;
    reset = 1'b1;
    #1;
    chk("mid_rst_tx_load", bus.tx_load, 0);
    chk("mid_rst_req_ack", bus.req_ack, 0);
    chk("mid_rst_locked", bus.locked, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_grant", bus.grant, 0);
    chk("mid_rst_tx_char", bus.tx_char, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_hold_pending", exp_q.size(), 3);
    tx_hold = 1'b0;
    wait_done("mid_done", 400);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
